// File: rtl/window_line_buffer.sv
// window_line_buffer: streaming K x K sliding-window generator.
// Holds K-1 previous rows in line buffers plus a K x K window register and
// emits each complete window (subject to stride) on a valid/ready output.
//
// Handshake: a pixel transfers on in_valid && in_ready, and a window on
// out_valid && out_ready. in_ready = !out_valid || out_ready, so a new pixel
// is taken only when the current window is absent or draining this cycle.
// Once raised, out_valid and the window payload hold until the window drains.
module window_line_buffer #(
   parameter int DATA_W = 18,
   parameter int IMG_W  = 13,
   parameter int IMG_H  = 13,
   parameter int K      = 3,
   parameter int STRIDE = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clear,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DATA_W-1:0]             in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_W*K*K-1:0]         out_window,
   output logic [$clog2(IMG_H)-1:0]      out_row,
   output logic [$clog2(IMG_W)-1:0]      out_col,
   output logic                          out_last,
   output logic                          frame_done
);

   localparam int RW       = $clog2(IMG_H);
   localparam int CW       = $clog2(IMG_W);
   localparam int LAST_ROW = ((IMG_H - K) / STRIDE) * STRIDE;
   localparam int LAST_COL = ((IMG_W - K) / STRIDE) * STRIDE;

   // Line buffers: row 0 is the oldest stored row.
   logic [DATA_W-1:0] lb_q  [K-1][IMG_W];
   // Window register: win_q[r][c], r = 0 oldest row, c = 0 leftmost column.
   logic [DATA_W-1:0] win_q [K][K];
   logic [DATA_W-1:0] new_col [K];

   logic [RW-1:0] row_q, row_d, row_rel;
   logic [CW-1:0] col_q, col_d, col_rel;
   logic          out_valid_q, out_last_q, frame_done_q;
   logic [RW-1:0] out_row_q;
   logic [CW-1:0] out_col_q;

   logic accept, col_last, row_last, qual, last_win;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   assign col_last = (col_q == CW'(IMG_W - 1));
   assign row_last = (row_q == RW'(IMG_H - 1));
   assign row_rel  = row_q - RW'(K - 1);
   assign col_rel  = col_q - CW'(K - 1);

   // The accepted pixel completes a window when it is the bottom-right corner
   // of a window whose top-left lands on the stride grid.
   assign qual = (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1)) &&
                 ((32'(row_rel) % STRIDE) == 0) &&
                 ((32'(col_rel) % STRIDE) == 0);
   assign last_win = (row_rel == RW'(LAST_ROW)) && (col_rel == CW'(LAST_COL));

   // Incoming column: stored rows at this column (oldest on top), new pixel last.
   always_comb begin
      for (int j = 0; j < K - 1; j++) begin
         new_col[j] = lb_q[j][col_q];
      end
      new_col[K-1] = in_data;
   end

   // Raster position that follows the current pixel.
   always_comb begin
      row_d = row_q;
      col_d = col_q + CW'(1);
      if (col_last) begin
         col_d = '0;
         row_d = row_last ? '0 : row_q + RW'(1);
      end
   end

   // Line-buffer column shifts up by one row on every accepted pixel.
   always_ff @(posedge clk) begin
      if (accept && !clear) begin
         for (int j = 0; j < K - 2; j++) begin
            lb_q[j][col_q] <= lb_q[j+1][col_q];
         end
         lb_q[K-2][col_q] <= in_data;
      end
   end

   // Position counters, window shift and output handshake state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_q        <= '0;
         col_q        <= '0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         frame_done_q <= 1'b0;
         out_row_q    <= '0;
         out_col_q    <= '0;
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
               win_q[r][c] <= '0;
            end
         end
      end else if (clear) begin
         // Abort drops any pending window; the accept of this cycle is discarded.
         row_q        <= '0;
         col_q        <= '0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= accept && row_last && col_last;
         if (accept) begin
            row_q <= row_d;
            col_q <= col_d;
            for (int r = 0; r < K; r++) begin
               for (int c = 0; c < K - 1; c++) begin
                  win_q[r][c] <= win_q[r][c+1];
               end
               win_q[r][K-1] <= new_col[r];
            end
            out_valid_q <= qual;
            if (qual) begin
               out_row_q  <= row_rel;
               out_col_q  <= col_rel;
               out_last_q <= last_win;
            end
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   // Flatten the window: element r*K + c at bits [(r*K+c)*DATA_W +: DATA_W].
   for (genvar r = 0; r < K; r++) begin : g_row
      for (genvar c = 0; c < K; c++) begin : g_col
         assign out_window[(r*K + c)*DATA_W +: DATA_W] = win_q[r][c];
      end
   end

   assign out_valid  = out_valid_q;
   assign out_row    = out_row_q;
   assign out_col    = out_col_q;
   assign out_last   = out_last_q;
   assign frame_done = frame_done_q;

endmodule

// File: doc/window_line_buffer.md
Name: window_line_buffer

Overview:
- Streaming K x K sliding-window generator for the CNN convolution stages.
- Accepts a raster-order pixel stream of one IMG_W x IMG_H feature map and holds K-1 previous rows in internal line buffers.
- Emits each complete K x K window with valid/ready handshake, configurable stride and an end-of-frame marker.
- Sits between a layer's output writer and the next layer's MAC array. It generalises the fixed 13x13, 3x3, 18-bit window RAM to parametrised sizes, with flow control, stride and frame tracking.

Parameters:
- DATA_W, 18, pixel width in bits.
- IMG_W, 13, pixels per row.
- IMG_H, 13, rows per frame.
- K, 3, window edge; legal range 2..IMG_W and K <= IMG_H.
- STRIDE, 1, window step in both dimensions; legal values 1..K.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous frame abort; returns counters to frame start.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a pixel this cycle.
- in_data  input  DATA_W  pixel, raster order, row-major.
- out_valid  output  1  out_window holds a valid window.
- out_ready  input  1  consumer accepts the window.
- out_window  output  DATA_W*K*K  window element i is at bits [i*DATA_W +: DATA_W].
- out_row  output  clog2(IMG_H)  top row of the emitted window.
- out_col  output  clog2(IMG_W)  left column of the emitted window.
- out_last  output  1  final window of the frame; valid with out_valid.
- frame_done  output  1  one-cycle pulse on acceptance of pixel (IMG_H-1, IMG_W-1).

Behaviour:
- Reset values:
  - out_valid, out_last, frame_done = 0.
  - out_window, out_row, out_col = 0.
  - Pixel row and column counters = 0.
  - Line-buffer contents are not reset.
- in_ready = !out_valid || out_ready (combinational). A pixel is accepted when in_valid && in_ready.
- On accept:
  - The window register shifts one column left.
  - The new rightmost column is the K-1 line-buffer entries at the current column, oldest row at top, with in_data at the bottom.
  - The line buffers at the current column shift upward by one row.
  - The column counter increments and wraps at IMG_W-1; the row counter then increments and wraps at IMG_H-1 to 0, starting the next frame.
- Window ordering: i = r*K + c.
  - r = 0 is the oldest row; c = 0 is the leftmost column.
  - Element K*K-1 is the pixel just accepted.
  - For K=3 this gives element order top-left .. bottom-right.
- A window qualifies when the accepted pixel is at (row, col) with row >= K-1, col >= K-1, (row-K+1) % STRIDE == 0 and (col-K+1) % STRIDE == 0.
- The qualifying accept sets out_valid the next cycle and loads out_row = row-K+1 and out_col = col-K+1. Latency is one cycle from accept to out_valid.
- A non-qualifying accept with out_ready high clears out_valid.
- out_valid holds, and out_window/out_row/out_col/out_last stay stable, until out_valid && out_ready.
- Accept and drain in the same cycle is allowed: the output is replaced with no bubble, giving full throughput of 1 pixel/cycle.
- out_last = 1 when out_row == ((IMG_H-K)/STRIDE)*STRIDE and out_col == ((IMG_W-K)/STRIDE)*STRIDE (integer division).
- Windows per frame = ((IMG_W-K)/STRIDE+1) * ((IMG_H-K)/STRIDE+1).
- frame_done is registered and high for exactly one cycle after the final pixel is accepted, independent of the output handshake.
- clear:
  - Zeroes the counters and out_valid and drops any pending window. in_ready is 1 the next cycle.
  - Line-buffer data is not cleared; row gating prevents stale output.
  - clear has priority over a simultaneous accept, which is discarded.
- Reset mid-frame has the same effect as clear, applied asynchronously.
- Storage: (K-1) x IMG_W x DATA_W line buffers (inferable as RAM or registers) plus a K x K register window. Synthesis target is the DE0-Nano.

Test Plan:
- Default params, pixels 0..168 with in_valid=1 and out_ready=1:
  - First out_valid follows the accept of pixel 28, with window {0,1,2,13,14,15,26,27,28} and out_row=0, out_col=0.
  - 121 windows are emitted in total.
  - The last window is {140,141,142,153,154,155,166,167,168} with out_last=1.
  - frame_done pulses once.
- Backpressure: hold out_ready=0 for 5 cycles after the first window.
  - in_ready=0 and out_window stays stable over those cycles.
  - Pixel 29 is not consumed while stalled.
  - After release, the next window is {1,2,3,14,15,16,27,28,29}.
- STRIDE=2: same stream gives exactly 36 windows.
  - The second window has out_col=2 and window {2,3,4,15,16,17,28,29,30}.
  - out_last is set at out_row=10, out_col=10.
- Random in_valid/out_ready toggling (50%) over 3 back-to-back frames: window contents match the reference model, 121 windows per frame, and no drops or duplicates.
- Assert clear after pixel 60, then restart the stream at 0: no window is emitted before the new pixel 28, and the first window is {0,1,2,13,14,15,26,27,28}.
- Assert rst_n low for 1 cycle mid-window while out_valid=1: outputs return to 0 immediately; a fresh frame then behaves as in the first scenario.
